ibex_wb_stage_sync: RTL and testbench

Writeback stage placed directly downstream of the execute block and the LSU. It captures one completed EX-stage instruction per cycle. It then performs the register-file write: the EX result for ALU, multiplier/divider and CSR instructions, or load data once the LSU responds. It signals retirement and provides writeback-stage forwarding information back to ID. It holds at most one instruction and back-pressures ID/EX through `ready_wb_o`.

---
 rtl/ibex_pkg.sv | 12 +
 rtl/ibex_wb_stage_sync.sv | 150 +++++++++++++++
 tb/tb_ibex_wb_stage_sync.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the Ibex core slice: writeback-stage instruction classification.
package ibex_pkg;

    localparam int unsigned WB_INSTR_TYPE_W = 2;

    typedef enum logic [WB_INSTR_TYPE_W-1:0] {
        WB_INSTR_LOAD  = 2'd0,
        WB_INSTR_STORE = 2'd1,
        WB_INSTR_OTHER = 2'd2
    } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_stage_sync.sv
// Writeback stage: one-entry buffer between EX/LSU and the register file, retiring
// EX results after one cycle and loads/stores when the LSU responds.
module ibex_wb_stage_sync
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,

    input  logic           en_wb_i,
    input  wb_instr_type_e instr_type_wb_i,
    input  logic [31:0]    pc_id_i,
    input  logic [4:0]     rf_waddr_id_i,
    input  logic [31:0]    rf_wdata_id_i,
    input  logic           rf_we_id_i,

    input  logic           lsu_resp_valid_i,
    input  logic           lsu_resp_err_i,
    input  logic [31:0]    lsu_rdata_i,

    output logic           ready_wb_o,
    output logic [4:0]     rf_waddr_wb_o,
    output logic [31:0]    rf_wdata_wb_o,
    output logic           rf_we_wb_o,
    output logic           rf_write_wb_o,
    output logic           outstanding_load_wb_o,
    output logic           outstanding_store_wb_o,
    output logic           instr_done_wb_o,
    output logic           lsu_err_wb_o,
    output logic [31:0]    pc_wb_o
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        VALID    = 2'd1,
        WAIT_LSU = 2'd2
    } wb_state_e;

    wb_state_e             state_q, state_d;
    wb_instr_type_e        type_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     waddr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     pc_q;
    logic                  accept;

    // An instruction is taken only when the buffer is free or retiring this cycle.
    assign accept = en_wb_i & ready_wb_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:    state_d = EMPTY;
            VALID:    state_d = EMPTY;
            WAIT_LSU: if (lsu_resp_valid_i) state_d = EMPTY;
            default:  state_d = EMPTY;
        endcase
        if (accept) begin
            state_d = (instr_type_wb_i == WB_INSTR_OTHER) ? VALID : WAIT_LSU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            type_q <= WB_INSTR_LOAD;
            we_q   <= 1'b0;
        end else if (accept) begin
            type_q <= instr_type_wb_i;
            we_q   <= rf_we_id_i;
        end
    end

    // Payload registers only need clearing when ResetAll is set; outputs are masked in EMPTY.
    always_ff @(posedge clk_i) begin
        if (rst_i && ResetAll) begin
            waddr_q <= ADDR_W'(0);
            wdata_q <= DATA_W'(0);
            pc_q    <= DATA_W'(0);
        end else if (accept) begin
            waddr_q <= rf_waddr_id_i;
            wdata_q <= rf_wdata_id_i;
            pc_q    <= pc_id_i;
        end
    end

    always_comb begin
        ready_wb_o             = 1'b0;
        rf_waddr_wb_o          = ADDR_W'(0);
        rf_wdata_wb_o          = DATA_W'(0);
        rf_we_wb_o             = 1'b0;
        rf_write_wb_o          = 1'b0;
        outstanding_load_wb_o  = 1'b0;
        outstanding_store_wb_o = 1'b0;
        instr_done_wb_o        = 1'b0;
        lsu_err_wb_o           = 1'b0;
        pc_wb_o                = DATA_W'(0);
        unique case (state_q)
            EMPTY: begin
                ready_wb_o = 1'b1;
            end
            VALID: begin
                ready_wb_o      = 1'b1;
                instr_done_wb_o = 1'b1;
                rf_waddr_wb_o   = waddr_q;
                rf_wdata_wb_o   = wdata_q;
                rf_we_wb_o      = we_q;
                rf_write_wb_o   = we_q;
                pc_wb_o         = pc_q;
            end
            WAIT_LSU: begin
                rf_waddr_wb_o          = waddr_q;
                rf_wdata_wb_o          = wdata_q;
                rf_write_wb_o          = we_q;
                pc_wb_o                = pc_q;
                outstanding_load_wb_o  = (type_q == WB_INSTR_LOAD);
                outstanding_store_wb_o = (type_q == WB_INSTR_STORE);
                if (lsu_resp_valid_i) begin
                    ready_wb_o      = 1'b1;
                    instr_done_wb_o = 1'b1;
                    lsu_err_wb_o    = lsu_resp_err_i;
                    // Load data bypasses the buffer so it is written in the response cycle.
                    if ((type_q == WB_INSTR_LOAD) && !lsu_resp_err_i) begin
                        rf_we_wb_o    = we_q;
                        rf_wdata_wb_o = lsu_rdata_i;
                    end
                end
            end
            default: begin
                ready_wb_o = 1'b1;
            end
        endcase
    end

    // Upstream must not present an instruction while WB is full.
    a_no_enter_when_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        !(en_wb_i && !ready_wb_o));

endmodule

// File: tb/tb_ibex_wb_stage_sync.sv
// Directed bench for ibex_wb_stage_sync: retire scoreboard plus per-cycle output checks.
module tb_ibex_wb_stage_sync;
    import ibex_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] pc;
    } retire_t;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           en_wb_i;
    wb_instr_type_e instr_type_wb_i;
    logic [31:0]    pc_id_i;
    logic [4:0]     rf_waddr_id_i;
    logic [31:0]    rf_wdata_id_i;
    logic           rf_we_id_i;
    logic           lsu_resp_valid_i;
    logic           lsu_resp_err_i;
    logic [31:0]    lsu_rdata_i;
    logic           ready_wb_o;
    logic [4:0]     rf_waddr_wb_o;
    logic [31:0]    rf_wdata_wb_o;
    logic           rf_we_wb_o;
    logic           rf_write_wb_o;
    logic           outstanding_load_wb_o;
    logic           outstanding_store_wb_o;
    logic           instr_done_wb_o;
    logic           lsu_err_wb_o;
    logic [31:0]    pc_wb_o;

    int checks = 0;
    int errors = 0;
    retire_t sb[$];

    always #5 clk_i = ~clk_i;

    ibex_wb_stage_sync dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .en_wb_i                (en_wb_i),
        .instr_type_wb_i        (instr_type_wb_i),
        .pc_id_i                (pc_id_i),
        .rf_waddr_id_i          (rf_waddr_id_i),
        .rf_wdata_id_i          (rf_wdata_id_i),
        .rf_we_id_i             (rf_we_id_i),
        .lsu_resp_valid_i       (lsu_resp_valid_i),
        .lsu_resp_err_i         (lsu_resp_err_i),
        .lsu_rdata_i            (lsu_rdata_i),
        .ready_wb_o             (ready_wb_o),
        .rf_waddr_wb_o          (rf_waddr_wb_o),
        .rf_wdata_wb_o          (rf_wdata_wb_o),
        .rf_we_wb_o             (rf_we_wb_o),
        .rf_write_wb_o          (rf_write_wb_o),
        .outstanding_load_wb_o  (outstanding_load_wb_o),
        .outstanding_store_wb_o (outstanding_store_wb_o),
        .instr_done_wb_o        (instr_done_wb_o),
        .lsu_err_wb_o           (lsu_err_wb_o),
        .pc_wb_o                (pc_wb_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle();
        en_wb_i          = 1'b0;
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
        lsu_rdata_i      = 32'h0;
    endtask

    task automatic enter(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] wa,
                         input logic [31:0] wd, input logic we);
        en_wb_i         = 1'b1;
        instr_type_wb_i = t;
        pc_id_i         = pc;
        rf_waddr_id_i   = wa;
        rf_wdata_id_i   = wd;
        rf_we_id_i      = we;
    endtask

    task automatic expect_retire(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic err, input logic [31:0] pc);
        retire_t r;
        r.we = we; r.waddr = wa; r.wdata = wd; r.err = err; r.pc = pc;
        sb.push_back(r);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".ready"},  32'(ready_wb_o), 32'd1);
        chk({tag, ".done"},   32'(instr_done_wb_o), 32'd0);
        chk({tag, ".we"},     32'(rf_we_wb_o), 32'd0);
        chk({tag, ".write"},  32'(rf_write_wb_o), 32'd0);
        chk({tag, ".oload"},  32'(outstanding_load_wb_o), 32'd0);
        chk({tag, ".ostore"}, 32'(outstanding_store_wb_o), 32'd0);
        chk({tag, ".err"},    32'(lsu_err_wb_o), 32'd0);
        chk({tag, ".waddr"},  32'(rf_waddr_wb_o), 32'd0);
        chk({tag, ".wdata"},  rf_wdata_wb_o, 32'd0);
        chk({tag, ".pc"},     pc_wb_o, 32'd0);
    endtask

    // Retire monitor: every retire must match the oldest predicted instruction.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0) begin
            if (rf_we_wb_o) chk("we_without_done", 32'(instr_done_wb_o), 32'd1);
            if (instr_done_wb_o) begin
                chk("retire_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    retire_t r;
                    r = sb.pop_front();
                    chk("sb.we",    32'(rf_we_wb_o), 32'(r.we));
                    chk("sb.waddr", 32'(rf_waddr_wb_o), 32'(r.waddr));
                    chk("sb.err",   32'(lsu_err_wb_o), 32'(r.err));
                    chk("sb.pc",    pc_wb_o, r.pc);
                    if (r.we) chk("sb.wdata", rf_wdata_wb_o, r.wdata);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        idle();
        enter(WB_INSTR_OTHER, 32'h0, 5'd0, 32'h0, 1'b0);
        en_wb_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;
        sample();
        chk_empty("reset");

        // OTHER: write x5 one cycle after capture
        tick();
        enter(WB_INSTR_OTHER, 32'h100, 5'd5, 32'hDEADBEEF, 1'b1);
        expect_retire(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h100);
        tick();
        idle();
        sample();
        chk("other.we",    32'(rf_we_wb_o), 32'd1);
        chk("other.waddr", 32'(rf_waddr_wb_o), 32'd5);
        chk("other.wdata", rf_wdata_wb_o, 32'hDEADBEEF);
        chk("other.done",  32'(instr_done_wb_o), 32'd1);
        chk("other.ready", 32'(ready_wb_o), 32'd1);
        tick();
        sample();
        chk("other.n2.done",  32'(instr_done_wb_o), 32'd0);
        chk("other.n2.write", 32'(rf_write_wb_o), 32'd0);

        // LOAD x7; a response during the capture cycle is stale
        tick();
        enter(WB_INSTR_LOAD, 32'h200, 5'd7, 32'h0000AAAA, 1'b1);
        lsu_resp_valid_i = 1'b1;
        lsu_rdata_i      = 32'h00000BAD;
        expect_retire(1'b1, 5'd7, 32'h12345678, 1'b0, 32'h200);
        sample();
        chk("load.capture.done", 32'(instr_done_wb_o), 32'd0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("load.wait.oload", 32'(outstanding_load_wb_o), 32'd1);
            chk("load.wait.ready", 32'(ready_wb_o), 32'd0);
            chk("load.wait.we",    32'(rf_we_wb_o), 32'd0);
            chk("load.wait.write", 32'(rf_write_wb_o), 32'd1);
            tick();
        end
        lsu_resp_valid_i = 1'b1;
        lsu_rdata_i      = 32'h12345678;
        sample();
        chk("load.resp.wdata", rf_wdata_wb_o, 32'h12345678);
        chk("load.resp.ready", 32'(ready_wb_o), 32'd1);
        tick();
        idle();
        sample();
        chk("load.after.done", 32'(instr_done_wb_o), 32'd0);

        // STORE with bus error
        tick();
        enter(WB_INSTR_STORE, 32'h300, 5'd3, 32'h33333333, 1'b0);
        expect_retire(1'b0, 5'd3, 32'h0, 1'b1, 32'h300);
        tick();
        idle();
        sample();
        chk("store.ostore", 32'(outstanding_store_wb_o), 32'd1);
        chk("store.oload",  32'(outstanding_load_wb_o), 32'd0);
        tick();
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = 1'b1;
        sample();
        chk("store.err",  32'(lsu_err_wb_o), 32'd1);
        chk("store.done", 32'(instr_done_wb_o), 32'd1);
        chk("store.we",   32'(rf_we_wb_o), 32'd0);
        tick();

        // LOAD with bus error: no register write
        enter(WB_INSTR_LOAD, 32'h400, 5'd9, 32'h0, 1'b1);
        lsu_resp_valid_i = 1'b0;
        lsu_resp_err_i   = 1'b0;
        expect_retire(1'b0, 5'd9, 32'h0, 1'b1, 32'h400);
        tick();
        idle();
        lsu_resp_valid_i = 1'b1;
        lsu_resp_err_i   = 1'b1;
        lsu_rdata_i      = 32'h00000055;
        sample();
        chk("loaderr.we",   32'(rf_we_wb_o), 32'd0);
        chk("loaderr.err",  32'(lsu_err_wb_o), 32'd1);
        chk("loaderr.done", 32'(instr_done_wb_o), 32'd1);
        tick();

        // LOAD completing while an OTHER enters in the same cycle
        idle();
        enter(WB_INSTR_LOAD, 32'h600, 5'd12, 32'h0, 1'b1);
        expect_retire(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 32'h600);
        tick();
        idle();
        lsu_resp_valid_i = 1'b1;
        lsu_rdata_i      = 32'hCAFEF00D;
        enter(WB_INSTR_OTHER, 32'h604, 5'd13, 32'h00000013, 1'b1);
        expect_retire(1'b1, 5'd13, 32'h00000013, 1'b0, 32'h604);
        tick();
        idle();
        sample();
        chk("chain.done", 32'(instr_done_wb_o), 32'd1);
        tick();

        // Four back-to-back OTHER instructions, one retire per cycle
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            enter(WB_INSTR_OTHER, 32'h500 + 32'(4 * i), 5'(10 + i), d, 1'b1);
            expect_retire(1'b1, 5'(10 + i), d, 1'b0, 32'h500 + 32'(4 * i));
            sample();
            chk("b2b.ready", 32'(ready_wb_o), 32'd1);
            if (i > 0) chk("b2b.done", 32'(instr_done_wb_o), 32'd1);
            tick();
        end
        idle();
        sample();
        chk("b2b.last.done", 32'(instr_done_wb_o), 32'd1);
        tick();
        sample();
        chk("b2b.drain.done", 32'(instr_done_wb_o), 32'd0);

        // Reset while a LOAD waits, then a stale response
        tick();
        enter(WB_INSTR_LOAD, 32'h700, 5'd8, 32'h0, 1'b1);
        tick();
        idle();
        sample();
        chk("rstwait.oload", 32'(outstanding_load_wb_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sample();
        chk_empty("rstwait");
        tick();
        lsu_resp_valid_i = 1'b1;
        lsu_rdata_i      = 32'h00000099;
        sample();
        chk("stale.done", 32'(instr_done_wb_o), 32'd0);
        chk("stale.we",   32'(rf_we_wb_o), 32'd0);
        tick();
        idle();
        sample();
        chk("stale.after.ready", 32'(ready_wb_o), 32'd1);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
